// File: rtl/status_pkg.sv
// Shared timing defaults, counter sizing and button level encoding for the
// status-path front end.
package status_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT      = 32'd1_000_000;
    localparam int unsigned REPEAT_DELAY_DEFAULT  = 32'd25_000_000;
    localparam int unsigned REPEAT_PERIOD_DEFAULT = 32'd10_000_000;

    // Raw panel buttons are active-low, so the enum mirrors the pin level.
    typedef enum logic {
        PRESSED  = 1'b0,
        RELEASED = 1'b1
    } btn_level_t;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit) + 32'd1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One button lane: 2-FF synchroniser, debounce filter, arming and press-edge
// detection. press_edge is high on the edge where the stable level flips to pressed.
module debounce_filter
    import status_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press_edge,
    output logic held
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic [1:0]    primed_r;
    btn_level_t    stable_r;
    logic [CW-1:0] cnt_r;
    logic          armed_r;

    logic mismatch_s;
    logic terminal_s;
    logic release_s;

    assign mismatch_s = (sync2_r != stable_r);
    assign terminal_s = mismatch_s && (cnt_r == CW'(DEBOUNCE_CYCLES - 32'd1));
    assign press_edge = terminal_s && (stable_r == RELEASED) && armed_r;
    assign release_s  = terminal_s && (stable_r == PRESSED);
    // Once the release transition is committed the lane no longer counts as held.
    assign held       = (stable_r == PRESSED) && !release_s;

    // Synchroniser, debounce counter, stable level and arming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            primed_r <= 2'b00;
            stable_r <= RELEASED;
            cnt_r    <= {CW{1'b0}};
            armed_r  <= 1'b0;
        end else begin
            sync1_r  <= btn_n;
            sync2_r  <= sync1_r;
            primed_r <= {primed_r[0], 1'b1};

            if (!mismatch_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (terminal_s) begin
                cnt_r    <= {CW{1'b0}};
                stable_r <= btn_level_t'(sync2_r);
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end

            // Arm only after a genuine released sample has come through the
            // synchroniser, so a button held through reset never fires.
            if (primed_r[1] && (sync2_r == RELEASED) && (stable_r == RELEASED)) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

endmodule

// File: rtl/button_command_decoder.sv
// Turns the raw START/STOP and SELECT buttons into single-cycle command pulses,
// with auto-repeat on SELECT while it stays held.
module button_command_decoder
    import status_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_start_n,
    input  logic btn_select_n,
    output logic flip_working,
    output logic shift_selection
);

    localparam int unsigned HW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    logic rst_meta_r;
    logic rst_sync_r;
    logic start_press_s;
    logic start_held_unused_s;
    logic sel_press_s;
    logic sel_held_s;
    logic repeat_tick_s;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clk       (clk),
        .reset_n   (rst_sync_r),
        .btn_n     (btn_start_n),
        .press_edge(start_press_s),
        .held      (start_held_unused_s)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_select (
        .clk       (clk),
        .reset_n   (rst_sync_r),
        .btn_n     (btn_select_n),
        .press_edge(sel_press_s),
        .held      (sel_held_s)
    );

    if (REPEAT_DELAY != 32'd0) begin : g_repeat
        logic [HW-1:0] hold_cnt_r;
        logic          repeating_r;
        logic          in_period_r;
        logic [HW-1:0] limit_s;
        logic          tick_s;

        assign limit_s = in_period_r ? HW'(REPEAT_PERIOD - 32'd1) : HW'(REPEAT_DELAY - 32'd1);
        assign tick_s  = repeating_r && sel_held_s && (hold_cnt_r == limit_s);
        assign repeat_tick_s = tick_s;

        // Hold counter: initial delay phase, then fixed-period phase while held.
        always_ff @(posedge clk or negedge rst_sync_r) begin
            if (!rst_sync_r) begin
                hold_cnt_r  <= {HW{1'b0}};
                repeating_r <= 1'b0;
                in_period_r <= 1'b0;
            end else if (sel_press_s) begin
                hold_cnt_r  <= {HW{1'b0}};
                repeating_r <= 1'b1;
                in_period_r <= 1'b0;
            end else if (!sel_held_s || !repeating_r) begin
                hold_cnt_r  <= {HW{1'b0}};
                repeating_r <= 1'b0;
                in_period_r <= 1'b0;
            end else if (tick_s) begin
                hold_cnt_r  <= {HW{1'b0}};
                repeating_r <= 1'b1;
                in_period_r <= 1'b1;
            end else begin
                hold_cnt_r  <= hold_cnt_r + HW'(1);
                repeating_r <= repeating_r;
                in_period_r <= in_period_r;
            end
        end
    end else begin : g_no_repeat
        logic sel_held_unused_s;
        assign sel_held_unused_s = sel_held_s;
        assign repeat_tick_s     = 1'b0;
    end

    // Registered command pulses; both may fire in the same cycle.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            flip_working    <= 1'b0;
            shift_selection <= 1'b0;
        end else begin
            flip_working    <= start_press_s;
            shift_selection <= sel_press_s | repeat_tick_s;
        end
    end

endmodule

// File: tb/tb_button_command_decoder.sv
// Directed bench: stimulus pushes expected pulse cycles into per-output queues,
// a negedge monitor pops and compares every pulse the design produces.
module tb_button_command_decoder;

    logic clk          = 1'b0;
    logic reset_n      = 1'b0;
    logic btn_start_n  = 1'b1;
    logic btn_select_n = 1'b1;
    logic flip_working;
    logic shift_selection;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_flip[$];
    int exp_sel[$];

    button_command_decoder #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_start_n    (btn_start_n),
        .btn_select_n   (btn_select_n),
        .flip_working   (flip_working),
        .shift_selection(shift_selection)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic mon(input string name, input logic pulse, ref int q[$]);
        while (q.size() > 0 && q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed: got no pulse, expected pulse at cycle %0d", name, q[0]);
            void'(q.pop_front());
        end
        if (pulse) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected: got pulse at cycle %0d, expected none", name, cyc);
            end else if (q[0] != cyc) begin
                errors++;
                $display("FAIL %s early: got pulse at cycle %0d, expected cycle %0d", name, cyc, q[0]);
            end else begin
                void'(q.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon("flip_working", flip_working, exp_flip);
        mon("shift_selection", shift_selection, exp_sel);
    end

    initial begin
        int p;

        // Reset state
        step(3);
        check_bit("reset_flip", flip_working, 1'b0);
        check_bit("reset_sel", shift_selection, 1'b0);
        reset_n = 1'b1;
        step(10);

        // 1. Clean START press
        btn_start_n = 1'b0;
        exp_flip.push_back(cyc + 6);
        step(20);
        btn_start_n = 1'b1;
        step(15);

        // 2+3. Bounce on SELECT, then hold into auto-repeat
        for (int i = 0; i < 3; i++) begin
            btn_select_n = 1'b0;
            step(2);
            btn_select_n = 1'b1;
            step(2);
        end
        btn_select_n = 1'b0;
        p = cyc + 6;
        exp_sel.push_back(p);
        exp_sel.push_back(p + 10);
        for (int k = 13; k <= 28; k += 3) exp_sel.push_back(p + k);
        step(30);
        btn_select_n = 1'b1;
        step(20);

        // 5. Simultaneous presses
        btn_start_n  = 1'b0;
        btn_select_n = 1'b0;
        exp_flip.push_back(cyc + 6);
        exp_sel.push_back(cyc + 6);
        step(8);
        btn_start_n  = 1'b1;
        btn_select_n = 1'b1;
        step(20);

        // 4. START held through reset
        btn_start_n = 1'b0;
        reset_n     = 1'b0;
        #1;
        check_bit("held_reset_flip", flip_working, 1'b0);
        step(3);
        reset_n = 1'b1;
        step(50);
        btn_start_n = 1'b1;
        step(10);
        btn_start_n = 1'b0;
        exp_flip.push_back(cyc + 6);
        step(10);
        btn_start_n = 1'b1;
        step(20);

        // 6. Reset in the middle of an auto-repeat
        btn_select_n = 1'b0;
        p = cyc + 6;
        exp_sel.push_back(p);
        exp_sel.push_back(p + 10);
        step(16);
        #1;
        reset_n = 1'b0;
        #1;
        check_bit("midrep_reset_sel", shift_selection, 1'b0);
        check_bit("midrep_reset_flip", flip_working, 1'b0);
        step(1);
        reset_n = 1'b1;
        step(40);
        btn_select_n = 1'b1;
        step(10);
        btn_select_n = 1'b0;
        exp_sel.push_back(cyc + 6);
        step(8);
        btn_select_n = 1'b1;
        step(20);

        checks++;
        if (exp_flip.size() != 0) begin
            errors++;
            $display("FAIL flip_leftover: got %0d pulses outstanding, expected 0", exp_flip.size());
        end
        checks++;
        if (exp_sel.size() != 0) begin
            errors++;
            $display("FAIL sel_leftover: got %0d pulses outstanding, expected 0", exp_sel.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
